sched_seq_ctrl: RTL and testbench
=================================

Name: sched_seq_ctrl

Overview:
- Programmable schedule sequencer, the parametrised successor to the fixed per-schedule FSM controllers.
- Replaces a hard-coded cycle FSM with a loadable control store of DEPTH control words. Each word drives the datapath select, op and register-enable bus for WAIT+1 cycles.
- Adds a stall input, multi-cycle words, and programming while idle.
- Sits between the top-level start/done handshake and the shared ALU/MUL/LOG datapath.

Parameters:
- DEPTH, 16, number of control-store words; must be >= 2.
- CW_W, 32, payload width (concatenated unit selects, ops and register enables).
- WAIT_W, 3, width of the per-word extra-cycle count.
- AW, $clog2(DEPTH), derived address width; not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- stall  in  1  freeze sequencing while high (RUN only)
- prog_en  in  1  control-store write strobe
- prog_addr  in  AW  write address
- prog_data  in  CW_W+WAIT_W+1  word {last, wait, payload}
- op_ready  out  1  high in IDLE
- busy  out  1  high in RUN or DONE
- ctrl_word  out  CW_W  current payload; zero when ctrl_valid=0
- ctrl_valid  out  1  payload is live this cycle
- step_idx  out  AW  current word address (pc)
- result_en  out  1  final cycle of the last word
- done  out  1  one-cycle pulse after the run
- prog_err  out  1  registered one-cycle pulse: write attempted outside IDLE

Behaviour:
- States: IDLE, RUN, DONE. Registers are state, pc[AW], cnt[WAIT_W], the control store and prog_err.
- Reset (async) values:
  - state=IDLE, pc=0, cnt=0, prog_err=0.
  - All store words cleared to zero.
  - Outputs: op_ready=1, all others 0.
- IDLE:
  - op_ready=1.
  - prog_en=1 writes mem[prog_addr]=prog_data at the clock edge. prog_en has priority: start is ignored in that cycle.
  - Otherwise start=1 gives next state RUN with pc=0, cnt=0. The first word appears the cycle after start is sampled.
- RUN, stall=0:
  - ctrl_valid=1, ctrl_word=mem[pc].payload (combinational read), step_idx=pc.
  - If cnt < mem[pc].wait: cnt++.
  - Else (final cycle of the word):
    - If mem[pc].last=1 or pc==DEPTH-1: result_en=1, next state DONE.
    - Otherwise pc++ and cnt=0.
- RUN, stall=1:
  - ctrl_valid=0, ctrl_word=0, result_en=0. pc and cnt hold.
  - step_idx still shows pc.
- DONE: done=1 for one cycle, then IDLE and pc=0. stall is ignored.
- prog_en in RUN/DONE: write is dropped, the store is unchanged, and prog_err=1 in the next cycle.
- Word with wait=w is valid for w+1 unstalled cycles.
- Total unstalled latency from start sample to done pulse = sum over executed words of (wait+1), plus 1.
- An implicit last at pc==DEPTH-1 prevents pc wrap-around; pc never exceeds DEPTH-1.
- start while busy is ignored.
- stall and start together in IDLE: start is accepted.
- Reset mid-run: returns to IDLE immediately, outputs are zeroed and the store is cleared; the run is not resumed.
- All datapath-facing outputs are combinational from registered state and the store, with no glitch-filtering requirement.

Decomposition:
- Shared package sched_pkg:
  - state enum (IDLE/RUN/DONE).
  - localparams for word-field offsets: PAYLOAD_LSB=0, WAIT_LSB=CW_W, LAST_BIT=CW_W+WAIT_W.
- One sub-module, sched_cstore:
  - DEPTH x (CW_W+WAIT_W+1) register file.
  - Async clear on rst, one synchronous write port, one asynchronous read port.

Test Plan:
- Basic run: program words 0..3 as payload 0x11/0x22/0x33/0x44, waits 0/0/1/0, last on word 3, then pulse start. Expect ctrl_valid for 5 cycles with ctrl_word 0x11,0x22,0x33,0x33,0x44; result_en in the 5th cycle; done in the 6th; op_ready again in the 7th.
- Stall: same program with stall=1 for 2 cycles during word 2. Expect ctrl_word=0 and ctrl_valid=0 for those cycles, step_idx=2 held, and done delayed by exactly 2 cycles.
- Program during run: prog_en=1 to addr 1 while RUN. Expect prog_err pulse the next cycle and mem[1] unchanged on a readback run.
- No last flag (DEPTH=16, all waits 0, no last bits): expect 16 valid cycles, result_en at step_idx=15, done next cycle, no wrap to 0.
- start and prog_en together in IDLE: expect the write to happen and state to stay IDLE. A start the next cycle then runs the new word.
- Reset mid-run asserted at word 2: expect immediate op_ready=1 and ctrl_valid=0. A subsequent start with no reprogramming runs zero payloads through all 16 words.

Source files
------------

// File: rtl/sched_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sched_pkg
// Purpose  : Shared state encoding and control-word field layout for the
//            schedule sequencer.
// Revision : 1.0
// ============================================================================
package sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_CW_W    = 32;
   localparam int DEF_WAIT_W  = 3;

   // Control word layout: {last, wait, payload}
   localparam int PAYLOAD_LSB = 0;
   localparam int WAIT_LSB    = DEF_CW_W;
   localparam int LAST_BIT    = DEF_CW_W + DEF_WAIT_W;

   // Field offsets for non-default widths
   function automatic int wait_lsb(input int cw_w);
      return cw_w;
   endfunction

   function automatic int last_bit(input int cw_w, input int wait_w);
      return cw_w + wait_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sched_seq_ctrl_cstore.sv
`default_nettype none
// ============================================================================
// Module   : sched_cstore
// Purpose  : Control store register file, one sync write port, one async
//            read port, cleared asynchronously on reset.
// Revision : 1.0
// ============================================================================
module sched_cstore #(
   parameter int DEPTH  = 16,
   parameter int WORD_W = 36,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [WORD_W-1:0] i_wr_data,
   input  logic [AW-1:0]     i_rd_addr,
   output logic [WORD_W-1:0] o_rd_data
);

   logic [WORD_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/sched_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sched_seq_ctrl
// Purpose  : Programmable schedule sequencer driving the shared datapath from
//            a loadable control store, with stall and multi-cycle words.
// Revision : 1.0
// ============================================================================
module sched_seq_ctrl
   import sched_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int CW_W   = 32,
   parameter  int WAIT_W = 3,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stall,
   input  logic                   prog_en,
   input  logic [AW-1:0]          prog_addr,
   input  logic [CW_W+WAIT_W:0]   prog_data,
   output logic                   op_ready,
   output logic                   busy,
   output logic [CW_W-1:0]        ctrl_word,
   output logic                   ctrl_valid,
   output logic [AW-1:0]          step_idx,
   output logic                   result_en,
   output logic                   done,
   output logic                   prog_err
);

   localparam int          c_WORD_W   = CW_W + WAIT_W + 1;
   localparam int          c_WAIT_LSB = wait_lsb(CW_W);
   localparam int          c_LAST_BIT = last_bit(CW_W, WAIT_W);
   localparam logic [AW-1:0] c_LAST_PC = AW'(DEPTH - 1);

   state_t              r_state, w_state_nxt;
   logic [AW-1:0]       r_pc, w_pc_nxt;
   logic [WAIT_W-1:0]   r_cnt, w_cnt_nxt;
   logic                r_prog_err, w_prog_err_nxt;

   logic                w_wr_en;
   logic [c_WORD_W-1:0] w_word;
   logic [CW_W-1:0]     w_payload;
   logic [WAIT_W-1:0]   w_wait;
   logic                w_last;

   sched_cstore #(
      .DEPTH  (DEPTH),
      .WORD_W (c_WORD_W),
      .AW     (AW)
   ) u_cstore (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (prog_addr),
      .i_wr_data (prog_data),
      .i_rd_addr (r_pc),
      .o_rd_data (w_word)
   );

   assign w_payload = w_word[PAYLOAD_LSB +: CW_W];
   assign w_wait    = w_word[c_WAIT_LSB +: WAIT_W];
   assign w_last    = w_word[c_LAST_BIT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_pc       <= '0;
         r_cnt      <= '0;
         r_prog_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_cnt      <= w_cnt_nxt;
         r_prog_err <= w_prog_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_cnt_nxt      = r_cnt;
      w_wr_en        = 1'b0;
      w_prog_err_nxt = 1'b0;
      op_ready       = 1'b0;
      busy           = 1'b0;
      ctrl_word      = '0;
      ctrl_valid     = 1'b0;
      result_en      = 1'b0;
      done           = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            op_ready = 1'b1;
            // A write in the same cycle as start wins; start must be re-issued.
            if (prog_en) begin
               w_wr_en = 1'b1;
            end else if (start) begin
               w_state_nxt = ST_RUN;
               w_pc_nxt    = '0;
               w_cnt_nxt   = '0;
            end
         end
         ST_RUN: begin
            busy           = 1'b1;
            w_prog_err_nxt = prog_en;
            if (!stall) begin
               ctrl_valid = 1'b1;
               ctrl_word  = w_payload;
               if (r_cnt < w_wait) begin
                  w_cnt_nxt = r_cnt + WAIT_W'(1);
               end else if (w_last || (r_pc == c_LAST_PC)) begin
                  result_en   = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_pc_nxt  = r_pc + AW'(1);
                  w_cnt_nxt = '0;
               end
            end
         end
         ST_DONE: begin
            busy           = 1'b1;
            done           = 1'b1;
            w_prog_err_nxt = prog_en;
            w_state_nxt    = ST_IDLE;
            w_pc_nxt       = '0;
            w_cnt_nxt      = '0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_pc_nxt    = '0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign step_idx = r_pc;
   assign prog_err = r_prog_err;

endmodule
`default_nettype wire

// File: tb/tb_sched_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sched_seq_ctrl
// Purpose  : Self-checking bench for sched_seq_ctrl against a schedule-expansion
//            model, with directed scenarios and randomized traffic.
// Revision : 1.0
// ============================================================================
module tb_sched_seq_ctrl;

   localparam int DEPTH = 16;
   localparam int CW_W  = 32;
   localparam int WW    = 36;

   typedef logic [WW-1:0] word_t;

   typedef struct packed {
      logic [31:0] pl;
      logic [3:0]  idx;
      logic        res;
   } step_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] word;
      logic [3:0]  idx;
      logic        res;
      logic        dn;
      logic        op;
      logic        err;
   } rec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic          prog_en = 1'b0;
   logic [3:0]    prog_addr = '0;
   logic [WW-1:0] prog_data = '0;
   logic          op_ready, busy, ctrl_valid, result_en, done, prog_err;
   logic [31:0]   ctrl_word;
   logic [3:0]    step_idx;

   int n_checks = 0;
   int n_err    = 0;

   sched_seq_ctrl #(.DEPTH(DEPTH), .CW_W(CW_W), .WAIT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stall      (stall),
      .prog_en    (prog_en),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .op_ready   (op_ready),
      .busy       (busy),
      .ctrl_word  (ctrl_word),
      .ctrl_valid (ctrl_valid),
      .step_idx   (step_idx),
      .result_en  (result_en),
      .done       (done),
      .prog_err   (prog_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the program is expanded into the list of cycles it must produce
   word_t m_mem [DEPTH];
   step_t exp_q[$];
   int    phase  = 0;   // 0 idle, 1 running schedule, 2 done pulse
   logic  m_err  = 1'b0;
   logic [3:0] m_last = '0;

   initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

   function automatic void expand();
      word_t w;
      int    wt;
      exp_q.delete();
      for (int a = 0; a < DEPTH; a++) begin
         w  = m_mem[a];
         wt = int'(w[34:32]);
         for (int c = 0; c <= wt; c++)
            exp_q.push_back('{pl: w[31:0], idx: a[3:0],
                              res: (c == wt) && (w[35] || a == DEPTH - 1)});
         if (w[35]) break;
      end
   endfunction

   always @(posedge clk) begin
      step_t e;
      if (rst) begin
         phase = 0;
         m_err = 1'b0;
         exp_q.delete();
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end else begin
         m_err = (phase != 0) && prog_en;
         case (phase)
            0: if (prog_en) m_mem[prog_addr] = prog_data;
               else if (start) begin expand(); phase = 1; end
            1: if (!stall) begin
                  e = exp_q.pop_front();
                  if (e.res) begin phase = 2; m_last = e.idx; end
               end
            default: phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      logic e_op, e_busy, e_valid, e_res, e_done, e_err;
      logic [31:0] e_word;
      logic [3:0]  e_idx;
      e_op = 1'b0; e_busy = 1'b0; e_valid = 1'b0; e_res = 1'b0;
      e_done = 1'b0; e_err = 1'b0; e_word = '0; e_idx = '0;
      if (!rst) begin
         e_err = m_err;
         case (phase)
            0: e_op = 1'b1;
            1: begin
               e_busy = 1'b1;
               e_idx  = exp_q[0].idx;
               if (!stall) begin
                  e_valid = 1'b1;
                  e_word  = exp_q[0].pl;
                  e_res   = exp_q[0].res;
               end
            end
            default: begin
               e_busy = 1'b1;
               e_done = 1'b1;
               e_idx  = m_last;
            end
         endcase
      end else begin
         e_op = 1'b1;
      end
      chk("op_ready",   32'(op_ready),   32'(e_op));
      chk("busy",       32'(busy),       32'(e_busy));
      chk("ctrl_valid", 32'(ctrl_valid), 32'(e_valid));
      chk("ctrl_word",  ctrl_word,       e_word);
      chk("step_idx",   32'(step_idx),   32'(e_idx));
      chk("result_en",  32'(result_en),  32'(e_res));
      chk("done",       32'(done),       32'(e_done));
      chk("prog_err",   32'(prog_err),   32'(e_err));
   end

   // Trace recorder used by the literal scenario checks
   rec_t rec_q[$];
   logic rec_en = 1'b0;
   always @(negedge clk)
      if (rec_en) rec_q.push_back('{valid: ctrl_valid, word: ctrl_word, idx: step_idx,
                                    res: result_en, dn: done, op: op_ready, err: prog_err});

   function automatic word_t mkw(input logic last, input logic [2:0] wt, input logic [31:0] pl);
      return {last, wt, pl};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input int a, input word_t w);
      prog_en   = 1'b1;
      prog_addr = a[3:0];
      prog_data = w;
      tick();
      prog_en   = 1'b0;
   endtask

   task automatic prog_basic();
      prog(0, mkw(1'b0, 3'd0, 32'h11));
      prog(1, mkw(1'b0, 3'd0, 32'h22));
      prog(2, mkw(1'b0, 3'd1, 32'h33));
      prog(3, mkw(1'b1, 3'd0, 32'h44));
   endtask

   // Runs one schedule; rec_q[k-1] holds cycle k after the start sample.
   task automatic run_rec(input int st_from, input int st_len, input int pg_cyc);
      bit seen = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      rec_q.delete();
      rec_en = 1'b1;
      for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
         stall     = (cyc >= st_from) && (cyc < st_from + st_len);
         prog_en   = (cyc == pg_cyc);
         prog_addr = 4'd1;
         prog_data = mkw(1'b1, 3'd0, 32'hDEAD);
         tick();
         seen = rec_q[$].dn;
      end
      stall   = 1'b0;
      prog_en = 1'b0;
      if (!seen) chk("run_timeout", 32'd0, 32'd1);
      tick();
      rec_en = 1'b0;
   endtask

   int nvalid;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("reset_op_ready", 32'(op_ready), 32'd1);
      chk("reset_busy",     32'(busy),     32'd0);
      rst = 1'b0;
      tick();

      // Basic run
      prog_basic();
      run_rec(0, 0, -1);
      chk("basic_len", rec_q.size(), 7);
      chk("basic_w1", rec_q[0].word, 32'h11);
      chk("basic_w2", rec_q[1].word, 32'h22);
      chk("basic_w3", rec_q[2].word, 32'h33);
      chk("basic_w4", rec_q[3].word, 32'h33);
      chk("basic_w5", rec_q[4].word, 32'h44);
      chk("basic_res5", 32'(rec_q[4].res), 32'd1);
      chk("basic_res4", 32'(rec_q[3].res), 32'd0);
      chk("basic_done6", 32'(rec_q[5].dn), 32'd1);
      chk("basic_rdy7", 32'(rec_q[6].op), 32'd1);

      // Stall during word 2
      run_rec(3, 2, -1);
      chk("stall_valid3", 32'(rec_q[2].valid), 32'd0);
      chk("stall_word4",  rec_q[3].word, 32'd0);
      chk("stall_idx4",   32'(rec_q[3].idx), 32'd2);
      chk("stall_w5",     rec_q[4].word, 32'h33);
      chk("stall_done8",  32'(rec_q[7].dn), 32'd1);
      chk("stall_len",    rec_q.size(), 9);

      // Write attempt while running
      run_rec(0, 0, 2);
      chk("perr_pulse",  32'(rec_q[2].err), 32'd1);
      chk("perr_before", 32'(rec_q[1].err), 32'd0);
      chk("perr_after",  32'(rec_q[3].err), 32'd0);
      run_rec(0, 0, -1);
      chk("perr_readback", rec_q[1].word, 32'h22);
      chk("perr_rb_len", rec_q.size(), 7);

      // No last flag anywhere
      for (int i = 0; i < DEPTH; i++) prog(i, mkw(1'b0, 3'd0, 32'(i + 1)));
      run_rec(0, 0, -1);
      nvalid = 0;
      foreach (rec_q[k]) if (rec_q[k].valid) nvalid++;
      chk("nolast_valid", nvalid, 16);
      chk("nolast_res_idx", 32'(rec_q[15].idx), 32'd15);
      chk("nolast_res", 32'(rec_q[15].res), 32'd1);
      chk("nolast_done", 32'(rec_q[16].dn), 32'd1);

      // start together with prog_en in IDLE
      prog_en = 1'b1; start = 1'b1; prog_addr = 4'd0; prog_data = mkw(1'b1, 3'd0, 32'hAB);
      tick();
      prog_en = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("sp_idle", 32'(op_ready), 32'd1);
      tick();
      run_rec(0, 0, -1);
      chk("sp_word", rec_q[0].word, 32'hAB);
      chk("sp_done", 32'(rec_q[1].dn), 32'd1);

      // Reset mid-run at word 2
      prog_basic();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (step_idx == 4'd2) break;
      end
      chk("rr_reached", 32'(step_idx), 32'd2);
      #1 rst = 1'b1;
      #1;
      chk("rr_op_ready", 32'(op_ready), 32'd1);
      chk("rr_valid",    32'(ctrl_valid), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      run_rec(0, 0, -1);
      nvalid = 0;
      foreach (rec_q[k]) if (rec_q[k].valid && rec_q[k].word == 32'd0) nvalid++;
      chk("rr_zero_valid", nvalid, 16);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         stall     = ($urandom_range(0, 3) == 0);
         start     = ($urandom_range(0, 5) == 0);
         prog_en   = ($urandom_range(0, 7) == 0);
         prog_addr = 4'($urandom_range(0, 15));
         prog_data = {1'($urandom_range(0, 3) == 0), 3'($urandom), 32'($urandom)};
         rst       = ($urandom_range(0, 599) == 0);
         tick();
      end
      rst = 1'b0; stall = 1'b0; start = 1'b0; prog_en = 1'b0;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
